data_sync_ctrl: RTL and testbench

- Destination-domain bus synchronizer controller, directly downstream of the double-flop synchronizer stage.
- Consumes the already-synchronized request level and captures the quasi-static source bus.
- Issues a one-cycle enable pulse to the destination logic and returns an acknowledge level to the source, forming a 4-phase req/ack handshake.
- Holds capture while the destination is busy, and counts aborted requests.

---
 rtl/data_sync_ctrl.sv | 112 +++++++++++
 tb/tb_data_sync_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/data_sync_ctrl.sv
// Destination-side controller for a 4-phase req/ack bus synchronizer.
// Captures the source bus on a synchronized request edge, stalls on dst_busy, counts aborts.
module data_sync_ctrl #(
    parameter int unsigned BUS_WIDTH     = 8,
    parameter int unsigned ERR_CNT_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sync_req,
    input  logic [BUS_WIDTH-1:0]     unsync_bus,
    input  logic                     dst_busy,
    output logic [BUS_WIDTH-1:0]     sync_bus,
    output logic                     enable_pulse,
    output logic                     ack,
    output logic                     pending,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

    typedef enum logic [1:0] {StIdle, StPending, StAcked} state_e;

    state_e                   state_q, state_d;
    logic [BUS_WIDTH-1:0]     bus_q, bus_d;
    logic                     pulse_q, pulse_d;
    logic                     ack_q, ack_d;
    logic                     pend_q, pend_d;
    logic [ERR_CNT_WIDTH-1:0] err_q, err_d;
    logic                     req_dly_q, req_dly_d;
    logic                     run_q, run_d;

    always_comb begin
        state_d   = state_q;
        bus_d     = bus_q;
        pulse_d   = 1'b0;
        ack_d     = ack_q;
        pend_d    = pend_q;
        err_d     = err_q;
        req_dly_d = sync_req;
        run_d     = 1'b1;

        // First edge after reset release only primes req_dly, so a request
        // that is already high is never mistaken for a fresh rise.
        if (run_q) begin
            case (state_q)
                StIdle: begin
                    if (sync_req && !req_dly_q) begin
                        if (!dst_busy) begin
                            bus_d   = unsync_bus;
                            pulse_d = 1'b1;
                            ack_d   = 1'b1;
                            state_d = StAcked;
                        end else begin
                            pend_d  = 1'b1;
                            state_d = StPending;
                        end
                    end
                end
                StPending: begin
                    // Abort has priority over a simultaneous busy release.
                    if (!sync_req) begin
                        pend_d  = 1'b0;
                        state_d = StIdle;
                        if (err_q != {ERR_CNT_WIDTH{1'b1}}) begin
                            err_d = err_q + ERR_CNT_WIDTH'(1);
                        end
                    end else if (!dst_busy) begin
                        bus_d   = unsync_bus;
                        pulse_d = 1'b1;
                        ack_d   = 1'b1;
                        pend_d  = 1'b0;
                        state_d = StAcked;
                    end
                end
                StAcked: begin
                    if (!sync_req) begin
                        ack_d   = 1'b0;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            bus_q     <= '0;
            pulse_q   <= 1'b0;
            ack_q     <= 1'b0;
            pend_q    <= 1'b0;
            err_q     <= '0;
            req_dly_q <= 1'b0;
            run_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bus_q     <= bus_d;
            pulse_q   <= pulse_d;
            ack_q     <= ack_d;
            pend_q    <= pend_d;
            err_q     <= err_d;
            req_dly_q <= req_dly_d;
            run_q     <= run_d;
        end
    end

    assign sync_bus     = bus_q;
    assign enable_pulse = pulse_q;
    assign ack          = ack_q;
    assign pending      = pend_q;
    assign err_cnt      = err_q;

endmodule

// File: tb/tb_data_sync_ctrl.sv
// Self-checking bench for data_sync_ctrl: directed handshake scenarios plus
// randomized traffic compared every cycle against a behavioural handshake model.
module tb_data_sync_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sync_req = 1'b0;
    logic [7:0] unsync_bus = 8'h00;
    logic       dst_busy = 1'b0;
    logic [7:0] sync_bus;
    logic       enable_pulse;
    logic       ack;
    logic       pending;
    logic [3:0] err_cnt;

    int passed = 0;
    int total = 0;
    int pulses_seen = 0;
    bit chk_en = 1'b0;

    data_sync_ctrl #(.BUS_WIDTH(8), .ERR_CNT_WIDTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .sync_req     (sync_req),
        .unsync_bus   (unsync_bus),
        .dst_busy     (dst_busy),
        .sync_bus     (sync_bus),
        .enable_pulse (enable_pulse),
        .ack          (ack),
        .pending      (pending),
        .err_cnt      (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else passed++;
    endtask

    // Behavioural model: phase 0 = waiting for a fresh request, 1 = request
    // parked behind a busy destination, 2 = data handed over and acknowledged.
    int         m_phase = 0;
    logic [7:0] m_bus = 8'h00;
    logic       m_pulse = 1'b0;
    logic       m_ack = 1'b0;
    logic       m_pend = 1'b0;
    logic [3:0] m_err = 4'h0;
    logic       m_prev_req = 1'b0;
    logic       m_armed = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0; m_bus <= 8'h00; m_pulse <= 1'b0; m_ack <= 1'b0;
            m_pend <= 1'b0; m_err <= 4'h0; m_prev_req <= 1'b0; m_armed <= 1'b0;
        end else begin
            m_prev_req <= sync_req;
            m_armed    <= 1'b1;
            m_pulse    <= 1'b0;
            if (m_armed) begin
                if ((m_phase == 0 && sync_req && !m_prev_req && !dst_busy) ||
                    (m_phase == 1 && sync_req && !dst_busy)) begin
                    m_bus <= unsync_bus; m_pulse <= 1'b1; m_ack <= 1'b1;
                    m_pend <= 1'b0; m_phase <= 2;
                end else if (m_phase == 0 && sync_req && !m_prev_req) begin
                    m_pend <= 1'b1; m_phase <= 1;
                end else if (m_phase == 1 && !sync_req) begin
                    m_pend <= 1'b0; m_phase <= 0;
                    m_err  <= (m_err == 4'hF) ? 4'hF : m_err + 4'h1;
                end else if (m_phase == 2 && !sync_req) begin
                    m_ack <= 1'b0; m_phase <= 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("sync_bus", 32'(sync_bus), 32'(m_bus));
            check("enable_pulse", 32'(enable_pulse), 32'(m_pulse));
            check("ack", 32'(ack), 32'(m_ack));
            check("pending", 32'(pending), 32'(m_pend));
            check("err_cnt", 32'(err_cnt), 32'(m_err));
            if (enable_pulse === 1'b1) pulses_seen++;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    initial begin
        #1 rst = 1'b1;
        #1 chk_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("reset_err", 32'(err_cnt), 32'h0);
        check("reset_ack", 32'(ack), 32'h0);

        // Basic transfer
        unsync_bus = 8'hA5; sync_req = 1'b1;
        step();
        check("basic_bus", 32'(sync_bus), 32'hA5);
        check("basic_pulse", 32'(enable_pulse), 32'h1);
        check("basic_ack", 32'(ack), 32'h1);
        step();
        check("basic_pulse_w", 32'(enable_pulse), 32'h0);
        sync_req = 1'b0;
        step();
        check("basic_ack_drop", 32'(ack), 32'h0);

        // Stall behind busy destination
        dst_busy = 1'b1; unsync_bus = 8'h3C; sync_req = 1'b1;
        step();
        check("stall_pend", 32'(pending), 32'h1);
        check("stall_bus_held", 32'(sync_bus), 32'hA5);
        repeat (5) step();
        check("stall_pend_hold", 32'(pending), 32'h1);
        dst_busy = 1'b0;
        step();
        check("stall_bus", 32'(sync_bus), 32'h3C);
        check("stall_pulse", 32'(enable_pulse), 32'h1);
        check("stall_pend_clr", 32'(pending), 32'h0);
        sync_req = 1'b0;
        step();

        // Abort while pending
        dst_busy = 1'b1; unsync_bus = 8'h77; sync_req = 1'b1;
        step();
        step();
        sync_req = 1'b0;
        step();
        check("abort_pend", 32'(pending), 32'h0);
        check("abort_err", 32'(err_cnt), 32'h1);
        check("abort_ack", 32'(ack), 32'h0);
        check("abort_bus", 32'(sync_bus), 32'h3C);

        // Saturation: 16 more aborts, 17 in total
        for (int i = 0; i < 16; i++) begin
            sync_req = 1'b1; step();
            sync_req = 1'b0; step();
        end
        check("sat_err", 32'(err_cnt), 32'hF);

        // Back-to-back transfers at minimum spacing
        dst_busy = 1'b0;
        pulses_seen = 0;
        for (int v = 1; v <= 4; v++) begin
            unsync_bus = 8'(v); sync_req = 1'b1;
            step();
            check("b2b_bus", 32'(sync_bus), 32'(v));
            sync_req = 1'b0;
            step();
        end
        check("b2b_pulses", 32'(pulses_seen), 32'h4);

        // Reset in the acknowledged state with request held high
        unsync_bus = 8'h9A; sync_req = 1'b1;
        step();
        check("mid_ack_pre", 32'(ack), 32'h1);
        #1 rst = 1'b1;
        #1;
        check("mid_ack", 32'(ack), 32'h0);
        check("mid_bus", 32'(sync_bus), 32'h0);
        check("mid_err", 32'(err_cnt), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("mid_no_pulse", 32'(enable_pulse), 32'h0);
        end
        sync_req = 1'b0;
        step();
        sync_req = 1'b1;
        step();
        check("mid_new_pulse", 32'(enable_pulse), 32'h1);
        check("mid_new_bus", 32'(sync_bus), 32'h9A);

        // Randomized traffic, checked cycle by cycle against the model
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #2;
            if ($urandom_range(0, 249) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end else begin
                if (!sync_req) unsync_bus = 8'($urandom);
                if ($urandom_range(0, 3) == 0) sync_req = ~sync_req;
                dst_busy = ($urandom_range(0, 2) == 0);
            end
        end

        step();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
